// File: rtl/hud_pkg.sv
// Shared HUD types and constants for the life-icon sprite path.
package hud_pkg;

  localparam int SPRITE_ADDR_W = 19;
  localparam int SPRITE_DEPTH  = 3000;
  localparam int PIX_W         = 4;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [2:0]       life_t;

endpackage

// File: rtl/life_flash_tracker.sv
// Per-player blink timer: a life loss loads a frame down-counter, and while
// it runs the icon is blanked in the phases where the selected counter bit is 1.
module life_flash_tracker
  import hud_pkg::*;
#(
  parameter int FLASH_FRAMES = 32,
  parameter int BLINK_BIT    = 2
) (
  input  logic  Clk,
  input  logic  Reset,
  input  logic  frame_start,
  input  life_t life,
  output logic  blank_phase,
  output logic  active
);

  localparam logic [5:0] FLASH_LOAD = 6'(FLASH_FRAMES);

  life_t      prev_life_q;
  logic [5:0] flash_cnt_q;
  logic [5:0] flash_cnt_d;

  // Next count: a fresh loss reloads (even on a frame pulse), else count frames down.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (life < prev_life_q) begin
      flash_cnt_d = FLASH_LOAD;
    end else if (frame_start && (flash_cnt_q != 6'd0)) begin
      flash_cnt_d = flash_cnt_q - 6'd1;
    end
  end

  // Track the previous life value and the flash counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_life_q <= '0;
      flash_cnt_q <= '0;
    end else begin
      prev_life_q <= life;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign active      = (flash_cnt_q != 6'd0);
  assign blank_phase = flash_cnt_q[BLINK_BIT];

endmodule

// File: rtl/life_hud_arbiter.sv
// Shares one lifeROM port between the two players' HUD icon renderers:
// round-robin grant, two-stage registered read, id-tagged responses, and
// blinking of a player's icon for a while after a life is lost.
module life_hud_arbiter
  import hud_pkg::*;
#(
  parameter int ADDR_W       = SPRITE_ADDR_W,
  parameter int SPRITE_DEPTH = hud_pkg::SPRITE_DEPTH,
  parameter int FLASH_FRAMES = 32,
  parameter int BLINK_BIT    = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [2:0]        p0_life,
  input  logic [2:0]        p1_life,
  input  logic              p0_req_valid,
  input  logic              p1_req_valid,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [ADDR_W-1:0] p1_req_addr,
  output logic              p0_req_ready,
  output logic              p1_req_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        rom_life,
  input  logic [3:0]        rom_data,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [3:0]        rsp_data
);

  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(SPRITE_DEPTH);

  logic              prio_q;
  logic              gnt0, gnt1, gnt_any, gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  life_t             gnt_life;
  logic              blank0, blank1, active0, active1, gnt_blank;
  logic              s1_valid_q, s1_id_q, s1_oor_q, s1_blank_q;

  life_flash_tracker #(.FLASH_FRAMES(FLASH_FRAMES), .BLINK_BIT(BLINK_BIT)) u_flash0 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .life(p0_life),
    .blank_phase(blank0), .active(active0)
  );

  life_flash_tracker #(.FLASH_FRAMES(FLASH_FRAMES), .BLINK_BIT(BLINK_BIT)) u_flash1 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .life(p1_life),
    .blank_phase(blank1), .active(active1)
  );

  // Grant: a lone requester wins; on contention the priority pointer decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Reset) begin
      if (p0_req_valid && p1_req_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = p0_req_valid;
        gnt1 = p1_req_valid;
      end
    end
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign gnt_any      = gnt0 | gnt1;
  assign gnt_id       = gnt1;
  assign gnt_addr     = gnt_id ? p1_req_addr : p0_req_addr;
  assign gnt_life     = gnt_id ? p1_life : p0_life;
  // Blanking uses the counter as it stands in the grant cycle, before any reload.
  assign gnt_blank    = gnt_id ? (active1 & blank1) : (active0 & blank0);

  // Priority pointer hands the next contention to whoever was not just served.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prio_q <= 1'b0;
    end else if (gnt_any) begin
      prio_q <= ~gnt_id;
    end
  end

  // Stage 1: capture the granted request and drive the ROM address/select.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr   <= '0;
      rom_life   <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_blank_q <= 1'b0;
    end else begin
      s1_valid_q <= gnt_any;
      if (gnt_any) begin
        rom_addr   <= gnt_addr;
        rom_life   <= gnt_life;
        s1_id_q    <= gnt_id;
        s1_oor_q   <= (gnt_addr >= DEPTH_LIMIT);
        s1_blank_q <= gnt_blank;
      end
    end
  end

  // Stage 2: register the ROM pixel, forcing transparent when out of range or blinking off.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_valid_q;
      rsp_id    <= s1_id_q;
      rsp_data  <= (s1_oor_q || s1_blank_q) ? 4'd0 : rom_data;
    end
  end

endmodule

// File: tb/tb_life_hud_arbiter.sv
// Bench for life_hud_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_life_hud_arbiter;

  logic        Clk = 1'b0;
  logic        Reset, frame_start;
  logic [2:0]  p0_life, p1_life;
  logic        p0_req_valid, p1_req_valid;
  logic [18:0] p0_req_addr, p1_req_addr;
  logic        p0_req_ready, p1_req_ready;
  logic [18:0] rom_addr;
  logic [2:0]  rom_life;
  logic [3:0]  rom_data;
  logic        rsp_valid, rsp_id;
  logic [3:0]  rsp_data;

  life_hud_arbiter dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .p0_life(p0_life), .p1_life(p1_life),
    .p0_req_valid(p0_req_valid), .p1_req_valid(p1_req_valid),
    .p0_req_addr(p0_req_addr), .p1_req_addr(p1_req_addr),
    .p0_req_ready(p0_req_ready), .p1_req_ready(p1_req_ready),
    .rom_addr(rom_addr), .rom_life(rom_life), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 Clk = ~Clk;

  // Stand-in lifeROM: nonzero for every address when life is 1..3.
  function automatic logic [3:0] rom_fn(logic [18:0] a, logic [2:0] l);
    int v;
    if (l == 3'd0 || l > 3'd3) return 4'd0;
    v = ((int'(a) % 16) + int'(l) * 5) % 15 + 1;
    return v[3:0];
  endfunction

  assign rom_data = rom_fn(rom_addr, rom_life);

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit v;
    int id;
    int data;
  } rsp_t;

  // Model state
  int   m_prio;
  int   m_cnt[2];
  int   m_prev[2];
  int   m_addr, m_life;
  bit   m_rst_out;
  rsp_t m_s1, m_s2;
  rsp_t rsp_log[$];

  function automatic int model_winner(logic v0, logic v1, logic rst, int prio);
    if (rst) return -1;
    if (v0 && v1) return prio;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  initial begin
    m_prio = 0; m_cnt = '{0, 0}; m_prev = '{0, 0};
    m_addr = 0; m_life = 0; m_rst_out = 1'b0;
    m_s1 = '{1'b0, 0, 0}; m_s2 = '{1'b0, 0, 0};
  end

  // Behavioural model advanced on every rising edge.
  always @(posedge Clk) begin : model
    int w, addr, life, d;
    bit blank;
    int lives[2];
    w = model_winner(p0_req_valid, p1_req_valid, Reset, m_prio);
    lives[0] = int'(p0_life);
    lives[1] = int'(p1_life);
    if (Reset) begin
      m_prio = 0; m_cnt = '{0, 0}; m_prev = '{0, 0};
      m_addr = 0; m_life = 0; m_rst_out = 1'b1;
      m_s1 = '{1'b0, 0, 0}; m_s2 = '{1'b0, 0, 0};
    end else begin
      m_rst_out = 1'b0;
      m_s2 = m_s1;
      if (w >= 0) begin
        addr  = (w == 1) ? int'(p1_req_addr) : int'(p0_req_addr);
        life  = lives[w];
        blank = (m_cnt[w] != 0) && ((m_cnt[w] / 4) % 2 == 1);
        d     = (addr >= 3000 || blank) ? 0 : int'(rom_fn(19'(addr), 3'(life)));
        m_s1  = '{1'b1, w, d};
        m_addr = addr;
        m_life = life;
        m_prio = 1 - w;
      end else begin
        m_s1.v = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (lives[i] < m_prev[i]) m_cnt[i] = 32;
        else if (frame_start && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        m_prev[i] = lives[i];
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge Clk) begin : compare
    int w;
    w = model_winner(p0_req_valid, p1_req_valid, Reset, m_prio);
    check("p0_ready", int'(p0_req_ready), (w == 0) ? 1 : 0);
    check("p1_ready", int'(p1_req_ready), (w == 1) ? 1 : 0);
    check("rsp_valid", int'(rsp_valid), int'(m_s2.v));
    if (m_s2.v) begin
      check("rsp_id", int'(rsp_id), m_s2.id);
      check("rsp_data", int'(rsp_data), m_s2.data);
    end
    check("rom_addr", int'(rom_addr), m_addr);
    check("rom_life", int'(rom_life), m_life);
    if (m_rst_out) begin
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_data", int'(rsp_data), 0);
    end
    if (rsp_valid) rsp_log.push_back('{1'b1, int'(rsp_id), int'(rsp_data)});
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic one_req0(input logic [18:0] a, output int d);
    rsp_log.delete();
    p0_req_addr  = a;
    p0_req_valid = 1'b1;
    tick();
    p0_req_valid = 1'b0;
    repeat (4) tick();
    check("one_req_count", rsp_log.size(), 1);
    d = (rsp_log.size() > 0) ? rsp_log[0].data : -1;
  endtask

  int exp_cont_id[4]   = '{0, 1, 0, 1};
  int exp_cont_data[4] = '{1, 15, 1, 15};
  int exp_single[5]    = '{15, 1, 2, 3, 4};
  int oor_addr[3]      = '{3000, 524287, 2999};
  int exp_oor[3]       = '{0, 0, 13};

  initial begin : stim
    int d;
    Reset = 1'b1; frame_start = 1'b0;
    p0_life = 3'd1; p1_life = 3'd2;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    p0_req_addr = 19'd10; p1_req_addr = 19'd20;

    // Reset held with both requesters asking
    repeat (3) tick();
    #1;
    check("rst_p0_ready", int'(p0_req_ready), 0);
    check("rst_p1_ready", int'(p1_req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_rom_life", int'(rom_life), 0);

    // Contention straight out of reset: p0 first, then alternate
    Reset = 1'b0;
    rsp_log.delete();
    #1;
    for (int k = 0; k < 4; k++) begin
      check("cont_p0_ready", int'(p0_req_ready), (k % 2 == 0) ? 1 : 0);
      check("cont_p1_ready", int'(p1_req_ready), (k % 2 == 1) ? 1 : 0);
      tick();
      #1;
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (4) tick();
    check("cont_count", rsp_log.size(), 4);
    for (int k = 0; k < 4 && k < rsp_log.size(); k++) begin
      check("cont_id", rsp_log[k].id, exp_cont_id[k]);
      check("cont_data", rsp_log[k].data, exp_cont_data[k]);
    end

    // Single requester streaming
    rsp_log.delete();
    p1_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      p1_req_addr = 19'(100 + k);
      #1;
      check("single_p1_ready", int'(p1_req_ready), 1);
      tick();
    end
    p1_req_valid = 1'b0;
    repeat (4) tick();
    check("single_count", rsp_log.size(), 5);
    for (int k = 0; k < 5 && k < rsp_log.size(); k++) begin
      check("single_id", rsp_log[k].id, 1);
      check("single_data", rsp_log[k].data, exp_single[k]);
    end

    // Out-of-range addresses
    rsp_log.delete();
    p0_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p0_req_addr = 19'(oor_addr[k]);
      tick();
    end
    p0_req_valid = 1'b0;
    repeat (4) tick();
    check("oor_count", rsp_log.size(), 3);
    for (int k = 0; k < 3 && k < rsp_log.size(); k++)
      check("oor_data", rsp_log[k].data, exp_oor[k]);

    // Flash after a life loss
    p0_life = 3'd3;
    repeat (3) tick();
    check("model_no_flash_on_inc", m_cnt[0], 0);
    p0_life = 3'd2;
    tick();
    check("model_flash_load", m_cnt[0], 32);
    one_req0(19'd10, d); check("flash_cnt32_data", d, 6);
    pulses(4);
    check("model_flash_28", m_cnt[0], 28);
    one_req0(19'd10, d); check("flash_blank_data", d, 0);
    pulses(4);
    one_req0(19'd10, d); check("flash_cnt24_data", d, 6);
    pulses(24);
    check("model_flash_done", m_cnt[0], 0);
    one_req0(19'd10, d); check("flash_done_data", d, 6);

    // Decrement coinciding with a frame pulse reloads
    p0_life = 3'd1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("model_reload", m_cnt[0], 32);
    pulses(4);
    one_req0(19'd10, d); check("reload_blank_data", d, 0);
    pulses(28);

    // Increase never blanks
    p0_life = 3'd2; tick();
    p0_life = 3'd3; tick();
    pulses(4);
    one_req0(19'd10, d); check("inc_no_blank_data", d, 11);

    // Reset one cycle after a grant drops the in-flight response
    rsp_log.delete();
    p0_req_addr = 19'd50;
    p0_req_valid = 1'b1;
    tick();
    p0_req_valid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (4) tick();
    check("midrst_no_rsp", rsp_log.size(), 0);
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    #1;
    check("midrst_prio_p0", int'(p0_req_ready), 1);
    check("midrst_prio_p1", int'(p1_req_ready), 0);
    tick();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      Reset        = ($urandom_range(0, 299) == 0);
      frame_start  = ($urandom_range(0, 5) == 0);
      p0_req_valid = ($urandom_range(0, 9) < 7);
      p1_req_valid = ($urandom_range(0, 9) < 7);
      p0_req_addr  = ($urandom_range(0, 9) == 0) ? 19'($urandom_range(0, 524287))
                                                 : 19'($urandom_range(0, 3100));
      p1_req_addr  = ($urandom_range(0, 9) == 0) ? 19'($urandom_range(0, 524287))
                                                 : 19'($urandom_range(0, 3100));
      if ($urandom_range(0, 19) == 0) p0_life = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) p1_life = 3'($urandom_range(0, 3));
      tick();
    end
    Reset = 1'b0; frame_start = 1'b0;
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
